// File: rtl/ext_mem_arbiter_nch.sv
// ext_mem_arbiter_nch: N-channel arbiter for the external memory controller with
// fixed or round-robin selection, lockable grants and a hung-transaction watchdog.
module ext_mem_arbiter_nch #(
    parameter int N_CH     = 4,
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH-1:0]          reqBlock_i,
    input  logic [N_CH-1:0]          rw_i,
    input  logic [N_CH-1:0]          clear_i,
    input  logic [N_CH-1:0]          lock_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    input  logic [N_CH*ADDR_W-1:0]   add_i,
    output logic [N_CH-1:0]          grant_o,
    output logic [N_CH-1:0]          ready_o,
    output logic [N_CH-1:0]          done_o,
    output logic [N_CH-1:0]          valid_o,
    output logic [N_CH-1:0]          err_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     mem_req_o,
    output logic                     mem_reqBlock_o,
    output logic                     mem_rw_o,
    output logic                     mem_clear_o,
    output logic [ADDR_W-1:0]        mem_add_o,
    output logic [DATA_W-1:0]        mem_data_o,
    input  logic [DATA_W-1:0]        mem_data_i,
    input  logic                     mem_ready_i,
    input  logic                     mem_done_i,
    input  logic                     mem_valid_i
);
    localparam int IW = $clog2(N_CH);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d, rr_q, rr_d, win, sel;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_CH-1:0]   grant_q, grant_d, err_q, err_d, own_vec, hi_mask, req_hi;
    logic              mem_req_q, mem_req_d, blk_q, blk_d, rw_q, rw_d, clr_q, clr_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] add_a [N_CH];
    logic [DATA_W-1:0] data_a [N_CH];
    logic              idle, busy, hold, capture, abort;

    genvar k;
    for (k = 0; k < N_CH; k++) begin : g_slice
        assign add_a[k]  = add_i[k*ADDR_W +: ADDR_W];
        assign data_a[k] = data_i[k*DATA_W +: DATA_W];
    end

    function automatic logic [IW-1:0] lowest(input logic [N_CH-1:0] v);
        logic [IW-1:0] w;
        w = '0;
        for (int i = N_CH - 1; i >= 0; i--) if (v[i]) w = IW'(i);
        return w;
    endfunction

    // Round-robin: search the channels at/after rr_q first, then wrap to the low ones.
    assign hi_mask = ~((N_CH'(1) << rr_q) - N_CH'(1));
    assign req_hi  = req_i & hi_mask;
    assign win     = (ARB_MODE == 1 && |req_hi) ? lowest(req_hi) : lowest(req_i);

    assign idle    = state_q == IDLE;
    assign busy    = state_q == BUSY;
    assign hold    = state_q == HOLD;
    assign own_vec = N_CH'(1) << owner_q;
    assign sel     = idle ? win : owner_q;
    assign capture = mem_ready_i && (idle ? |req_i : hold && req_i[owner_q]);
    // A done on the threshold cycle wins over the watchdog.
    assign abort   = busy && TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1) && !mem_done_i;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = busy ? cnt_q + 1'b1 : '0;
        grant_d   = '0;
        err_d     = err_q;
        mem_req_d = state_q == ISSUE;
        blk_d     = blk_q;
        rw_d      = rw_q;
        clr_d     = clr_q;
        add_d     = add_q;
        wdata_d   = wdata_q;
        if (capture) begin
            state_d    = ISSUE;
            owner_d    = sel;
            grant_d    = N_CH'(1) << sel;
            err_d[sel] = 1'b0;
            blk_d      = reqBlock_i[sel];
            rw_d       = rw_i[sel];
            clr_d      = clear_i[sel];
            add_d      = add_a[sel];
            wdata_d    = data_a[sel];
        end
        if (capture && idle) rr_d = (sel == IW'(N_CH - 1)) ? '0 : sel + 1'b1;
        if (state_q == ISSUE) state_d = BUSY;
        if (busy && mem_done_i) state_d = lock_i[owner_q] ? HOLD : IDLE;
        if (abort) begin
            state_d = IDLE;
            err_d   = err_q | own_vec;
        end
        if (hold && !capture && !lock_i[owner_q] && !req_i[owner_q]) state_d = IDLE;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            err_q     <= '0;
            mem_req_q <= 1'b0;
            blk_q     <= 1'b0;
            rw_q      <= 1'b0;
            clr_q     <= 1'b0;
            add_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            mem_req_q <= mem_req_d;
            blk_q     <= blk_d;
            rw_q      <= rw_d;
            clr_q     <= clr_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
        end
    end

    assign grant_o        = grant_q;
    assign err_o          = err_q | (abort ? own_vec : '0);
    assign done_o         = (busy && (mem_done_i || abort)) ? own_vec : '0;
    assign valid_o        = (busy && mem_valid_i) ? own_vec : '0;
    assign ready_o        = (mem_ready_i && !reset_i) ? (idle ? '1 : hold ? own_vec : '0) : '0;
    assign data_o         = reset_i ? '0 : mem_data_i;
    assign mem_req_o      = mem_req_q;
    assign mem_reqBlock_o = blk_q;
    assign mem_rw_o       = rw_q;
    assign mem_clear_o    = clr_q | abort;
    assign mem_add_o      = add_q;
    assign mem_data_o     = wdata_q;
endmodule

// File: tb/tb_ext_mem_arbiter_nch.sv
// tb_ext_mem_arbiter_nch: randomized and directed bench for the memory arbiter, checking
// a fixed-priority and a round-robin instance driven from the same stimulus.
module tb_ext_mem_arbiter_nch;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] req = '0, blk = '0, rw = '0, clr = '0, lock = '0;
    logic [127:0] wdat = '0;
    logic [107:0] add = '0;
    logic [31:0] mdat = '0;
    logic mrdy = 1'b1, mdone = 1'b0, mvalid = 1'b0;
    logic [3:0] f_grant, f_ready, f_done, f_valid, f_err, r_grant, r_ready, r_done, r_valid, r_err;
    logic [31:0] f_data, r_data, f_mdat, r_mdat;
    logic [26:0] f_madd, r_madd;
    logic f_mreq, f_mblk, f_mrw, f_mclr, r_mreq, r_mblk, r_mrw, r_mclr;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ext_mem_arbiter_nch #(.N_CH(4), .ADDR_W(27), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(16)) u_f (
        .clock_i(clk), .reset_i(rst), .req_i(req), .reqBlock_i(blk), .rw_i(rw), .clear_i(clr),
        .lock_i(lock), .data_i(wdat), .add_i(add), .grant_o(f_grant), .ready_o(f_ready),
        .done_o(f_done), .valid_o(f_valid), .err_o(f_err), .data_o(f_data), .mem_req_o(f_mreq),
        .mem_reqBlock_o(f_mblk), .mem_rw_o(f_mrw), .mem_clear_o(f_mclr), .mem_add_o(f_madd),
        .mem_data_o(f_mdat), .mem_data_i(mdat), .mem_ready_i(mrdy), .mem_done_i(mdone),
        .mem_valid_i(mvalid));

    ext_mem_arbiter_nch #(.N_CH(4), .ADDR_W(27), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(16)) u_r (
        .clock_i(clk), .reset_i(rst), .req_i(req), .reqBlock_i(blk), .rw_i(rw), .clear_i(clr),
        .lock_i(lock), .data_i(wdat), .add_i(add), .grant_o(r_grant), .ready_o(r_ready),
        .done_o(r_done), .valid_o(r_valid), .err_o(r_err), .data_o(r_data), .mem_req_o(r_mreq),
        .mem_reqBlock_o(r_mblk), .mem_rw_o(r_mrw), .mem_clear_o(r_mclr), .mem_add_o(r_madd),
        .mem_data_o(r_mdat), .mem_data_i(mdat), .mem_ready_i(mrdy), .mem_done_i(mdone),
        .mem_valid_i(mvalid));

    function automatic int fixed_pick(input logic [3:0] r);
        for (int c = 0; c < 4; c++) if (r[c]) return c;
        return 0;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) if (r[(p + j) % 4]) return (p + j) % 4;
        return 0;
    endfunction

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; blk = '0; rw = '0; clr = '0; lock = '0;
        mdone = 1'b0; mvalid = 1'b0; mrdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns at the drive point of the first BUSY cycle (one cycle after the grant pulse).
    task automatic wait_grant(output logic [3:0] gf, output logic [3:0] gr, output logic mr);
        bit ok;
        gf = '0; gr = '0; mr = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (f_grant != 0 || r_grant != 0) begin
                gf = f_grant; gr = r_grant; mr = r_mreq; ok = 1'b1;
            end
            nxt();
        end
    endtask

    task automatic finish_txn(output logic [3:0] df, output logic [3:0] dr);
        mdone = 1'b1;
        @(negedge clk);
        df = f_done; dr = r_done;
        nxt();
        mdone = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        rst = 1'b1; mrdy = 1'b1; mdat = 32'hdeadbeef; req = 4'b1111;
        @(negedge clk);
        checks++; if ({f_grant, f_ready, f_done, f_valid, f_err, f_data, f_mreq, f_mblk, f_mrw, f_mclr, f_madd, f_mdat} !== '0) begin errors++; $display("FAIL reset_outputs got nonzero ready=%b data=%h", f_ready, f_data); end
        do_reset();
        req = 4'b0010;
        wait_grant(gf, gr, mr);
        req = '0; mvalid = 1'b1; mdat = 32'h5a5a;
        @(negedge clk);
        checks++; if (f_valid !== 4'b0010) begin errors++; $display("FAIL busy_valid got %b exp 0010", f_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({f_grant, f_ready, f_done, f_valid, f_err, f_data, f_mreq, f_mblk, f_mrw, f_mclr, f_madd, f_mdat} !== '0) begin errors++; $display("FAIL reset_mid_busy valid=%b data=%h ready=%b", f_valid, f_data, f_ready); end
        nxt();
        mvalid = 1'b0; rst = 1'b0; req = 4'b0100;
        wait_grant(gf, gr, mr);
        checks++; if (gf !== 4'b0100) begin errors++; $display("FAIL grant_after_reset got %b exp 0100", gf); end
        req = '0;
        finish_txn(df, dr);
    endtask

    task automatic test_fixed;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        do_reset();
        req = 4'b1010;
        for (int t = 0; t < 3; t++) begin
            wait_grant(gf, gr, mr);
            checks++; if (gf !== 4'b0010) begin errors++; $display("FAIL fixed_grant got %b exp 0010", gf); end
            finish_txn(df, dr);
        end
        req = 4'b1000;
        wait_grant(gf, gr, mr);
        checks++; if (gf !== 4'b1000) begin errors++; $display("FAIL fixed_ch3 got %b exp 1000", gf); end
        req = '0;
        finish_txn(df, dr);
    endtask

    task automatic test_rr;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(gf, gr, mr);
            checks++; if (gr !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_order got %b exp %b", gr, 4'(1 << (i % 4))); end
            checks++; if (mr !== 1'b0) begin errors++; $display("FAIL rr_req_with_grant got %b exp 0", mr); end
            @(negedge clk);
            checks++; if (r_mreq !== 1'b1) begin errors++; $display("FAIL rr_req_latency got %b exp 1", r_mreq); end
            nxt();
            finish_txn(df, dr);
        end
        req = '0;
    endtask

    task automatic test_random;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        int p = 0, wf, wr;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            req = 4'($urandom_range(1, 15));
            rw = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                add[c*27 +: 27] = 27'($urandom);
                wdat[c*32 +: 32] = $urandom;
            end
            wf = fixed_pick(req);
            wr = rr_pick(req, p);
            wait_grant(gf, gr, mr);
            checks++; if (gf !== 4'(1 << wf)) begin errors++; $display("FAIL rand_fixed_grant req=%b got %b exp %b", req, gf, 4'(1 << wf)); end
            checks++; if (gr !== 4'(1 << wr)) begin errors++; $display("FAIL rand_rr_grant req=%b got %b exp %b", req, gr, 4'(1 << wr)); end
            req = '0;
            @(negedge clk);
            checks++; if (f_mreq !== 1'b1) begin errors++; $display("FAIL rand_mem_req got %b exp 1", f_mreq); end
            checks++; if (f_madd !== add[wf*27 +: 27]) begin errors++; $display("FAIL rand_fixed_add got %h exp %h", f_madd, add[wf*27 +: 27]); end
            checks++; if (f_mdat !== wdat[wf*32 +: 32] || f_mrw !== rw[wf]) begin errors++; $display("FAIL rand_fixed_data got %h/%b exp %h/%b", f_mdat, f_mrw, wdat[wf*32 +: 32], rw[wf]); end
            checks++; if (r_madd !== add[wr*27 +: 27]) begin errors++; $display("FAIL rand_rr_add got %h exp %h", r_madd, add[wr*27 +: 27]); end
            nxt();
            repeat ($urandom_range(0, 4)) nxt();
            finish_txn(df, dr);
            checks++; if (df !== 4'(1 << wf) || dr !== 4'(1 << wr)) begin errors++; $display("FAIL rand_done got %b/%b exp %b/%b", df, dr, 4'(1 << wf), 4'(1 << wr)); end
            p = (wr + 1) % 4;
        end
        rw = '0;
    endtask

    task automatic test_lock;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        logic [26:0] a;
        do_reset();
        lock = 4'b0100; rw = 4'b0100; req = 4'b0100;
        for (int t = 0; t < 3; t++) begin
            a = 27'h100 + 27'(4 * t);
            add[2*27 +: 27] = a;
            wdat[2*32 +: 32] = $urandom;
            if (t > 0) req = 4'b0101;
            wait_grant(gf, gr, mr);
            checks++; if (gf !== 4'b0100) begin errors++; $display("FAIL lock_grant got %b exp 0100", gf); end
            req = 4'b0001;
            @(negedge clk);
            checks++; if (f_madd !== a || f_mrw !== 1'b1 || f_mdat !== wdat[2*32 +: 32]) begin errors++; $display("FAIL lock_fields got %h/%b exp %h/1", f_madd, f_mrw, a); end
            nxt();
            if (t == 2) lock = '0;
            finish_txn(df, dr);
            checks++; if (df !== 4'b0100) begin errors++; $display("FAIL lock_done got %b exp 0100", df); end
            if (t < 2) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++; if (f_grant !== 4'b0000 || f_ready !== 4'b0100) begin errors++; $display("FAIL lock_hold got grant %b ready %b exp 0000 0100", f_grant, f_ready); end
                    nxt();
                end
            end
        end
        wait_grant(gf, gr, mr);
        checks++; if (gf !== 4'b0001) begin errors++; $display("FAIL lock_release got %b exp 0001", gf); end
        req = '0; rw = '0;
        finish_txn(df, dr);
    endtask

    task automatic test_timeout;
        logic [3:0] gf, gr, df, dr, d16, e16;
        logic mr, c16;
        int n = 0;
        do_reset();
        req = 4'b0010;
        wait_grant(gf, gr, mr);
        req = '0; d16 = '0; e16 = '0; c16 = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (f_done != 0) begin
                n = i; d16 = f_done; e16 = f_err; c16 = f_mclr;
            end
            nxt();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycle got %0d exp 16", n); end
        checks++; if (d16 !== 4'b0010 || e16 !== 4'b0010 || c16 !== 1'b1) begin errors++; $display("FAIL timeout_abort got done %b err %b clr %b exp 0010 0010 1", d16, e16, c16); end
        @(negedge clk);
        checks++; if (f_ready !== 4'b1111 || f_err !== 4'b0010 || f_mclr !== 1'b0) begin errors++; $display("FAIL timeout_idle got ready %b err %b clr %b exp 1111 0010 0", f_ready, f_err, f_mclr); end
        nxt();
        req = 4'b0010;
        wait_grant(gf, gr, mr);
        req = '0;
        @(negedge clk);
        checks++; if (f_err !== 4'b0000) begin errors++; $display("FAIL err_cleared got %b exp 0000", f_err); end
        nxt();
        for (int i = 2; i <= 16; i++) begin
            if (i == 16) mdone = 1'b1;
            @(negedge clk);
            if (i == 16) begin
                d16 = f_done; e16 = f_err; c16 = f_mclr;
            end
            nxt();
        end
        mdone = 1'b0;
        checks++; if (d16 !== 4'b0010 || e16 !== 4'b0000 || c16 !== 1'b0) begin errors++; $display("FAIL threshold_done got done %b err %b clr %b exp 0010 0000 0", d16, e16, c16); end
        @(negedge clk);
        checks++; if (f_err !== 4'b0000 || f_ready !== 4'b1111) begin errors++; $display("FAIL threshold_idle got err %b ready %b exp 0000 1111", f_err, f_ready); end
        nxt();
    endtask

    task automatic test_block_read;
        logic [3:0] gf, gr, df, dr;
        logic mr;
        int pulses = 0;
        do_reset();
        req = 4'b1000; blk = 4'b1000; rw = 4'b0000;
        wait_grant(gf, gr, mr);
        checks++; if (gf !== 4'b1000) begin errors++; $display("FAIL block_grant got %b exp 1000", gf); end
        req = '0;
        @(negedge clk);
        checks++; if (f_mblk !== 1'b1 || f_mrw !== 1'b0) begin errors++; $display("FAIL block_fields got blk %b rw %b exp 1 0", f_mblk, f_mrw); end
        nxt();
        for (int b = 0; b < 8; b++) begin
            mvalid = 1'b1; mdat = 32'(b);
            @(negedge clk);
            if (f_valid === 4'b1000) pulses++;
            checks++; if (f_data !== 32'(b)) begin errors++; $display("FAIL block_data got %h exp %h", f_data, 32'(b)); end
            nxt();
        end
        mvalid = 1'b0;
        checks++; if (pulses != 8) begin errors++; $display("FAIL block_valid_pulses got %0d exp 8", pulses); end
        finish_txn(df, dr);
        checks++; if (df !== 4'b1000) begin errors++; $display("FAIL block_done got %b exp 1000", df); end
        mvalid = 1'b1; mdone = 1'b1; mdat = 32'hcafe;
        @(negedge clk);
        checks++; if (f_valid !== 4'b0000 || f_done !== 4'b0000 || f_data !== 32'hcafe) begin errors++; $display("FAIL idle_ignore got valid %b done %b data %h exp 0000 0000 cafe", f_valid, f_done, f_data); end
        nxt();
        mvalid = 1'b0; mdone = 1'b0; blk = '0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_random();
        test_lock();
        test_timeout();
        test_block_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end
endmodule
